// File: rtl/spi_pkg.sv
// Shared definitions for the mode-0 SPI master.
// Contents:
//   SPI_CPOL / SPI_CPHA / SPI_BYTE_BITS - fixed bus format (mode 0, byte framing)
//   SPI_CLK_DIV_50M                     - divider giving a 1 MHz SCK from the 50 MHz system clock
//   spi_state_e                         - controller state encoding
//   spi_timed_state()                   - states in which the SCK divider runs
package spi_pkg;

  localparam int SPI_CPOL      = 0;
  localparam int SPI_CPHA      = 0;
  localparam int SPI_BYTE_BITS = 8;

  localparam int SPI_SYS_CLK_HZ  = 50_000_000;
  localparam int SPI_SCK_HZ      = 1_000_000;
  localparam int SPI_CLK_DIV_50M = SPI_SYS_CLK_HZ / (2 * SPI_SCK_HZ);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_HOLD  = 3'd4
  } spi_state_e;

  // LOAD is deliberately excluded: the divider stays parked at zero while
  // waiting for TX data so every byte starts on a clean half-period boundary.
  function automatic logic spi_timed_state(input spi_state_e s);
    return (s == ST_SETUP) || (s == ST_SHIFT) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/spi_master_clkgen.sv
// SCK timing generator for the SPI master.
// Divides the system clock into SCK half-periods and counts them.
// Ports:
//   clk_i, rst_i  system clock, synchronous active-high reset
//   en_i          divider runs while high; counters are held at zero otherwise
//   clr_i         restart both counters (asserted on every state change)
//   shift_i       controller is shifting; qualifies the rise/fall strobes
//   tick_o        one-cycle strobe in the last system clock of a half-period
//   hp_o          index of the current half-period (0-based)
//   rise_o        SCK must rise at the end of this cycle
//   fall_o        SCK must fall at the end of this cycle
module spi_master_clkgen #(
  parameter int CLK_DIV = 25
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic       shift_i,
  output logic       tick_o,
  output logic [3:0] hp_o,
  output logic       rise_o,
  output logic       fall_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       hp_q, hp_d;

  assign tick_o = en_i && (div_q == DIV_LAST);
  assign hp_o   = hp_q;

  // Within SHIFT, even half-periods are SCK-low and odd ones SCK-high, so the
  // end of an even half-period is a rising edge and the end of an odd one a
  // falling edge.
  assign rise_o = tick_o && shift_i && !hp_q[0];
  assign fall_o = tick_o && shift_i &&  hp_q[0];

  always_comb begin
    div_d = div_q;
    hp_d  = hp_q;
    if (!en_i || clr_i) begin
      div_d = '0;
      hp_d  = '0;
    end else if (tick_o) begin
      div_d = '0;
      hp_d  = hp_q + 4'd1;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
      hp_q  <= '0;
    end else begin
      div_q <= div_d;
      hp_q  <= hp_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Byte-oriented SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, active-low SS.
// One transaction of LEN bytes per START; TX bytes via ready/valid, RX bytes
// as one-cycle valid pulses.
// Ports:
//   SPI_MASTER_CLOCK_50       system clock
//   SPI_MASTER_RESET_InHigh   synchronous active-high reset
//   SPI_MASTER_START_In       one-cycle transaction request (ignored while busy or LEN=0)
//   SPI_MASTER_LEN_InBus      byte count, sampled with START
//   SPI_MASTER_TXDATA_InBus   next TX byte
//   SPI_MASTER_TXVALID_In     TX byte valid
//   SPI_MASTER_TXREADY_Out    master takes TXDATA this cycle
//   SPI_MASTER_RXDATA_OutBus  last received byte
//   SPI_MASTER_RXVALID_Out    one-cycle pulse, RXDATA is new
//   SPI_MASTER_BUSY_Out       transaction in progress
//   SPI_MASTER_DONE_Out       one-cycle pulse at end of transaction
//   SPI_MASTER_SCK_Out        SPI clock
//   SPI_MASTER_MOSI_Out       serial data out
//   SPI_MASTER_MISO_In        serial data in
//   SPI_MASTER_SS_OutLow      slave select, active low
//
// state | meaning
// IDLE  | SS high, waiting for START with LEN != 0
// SETUP | SS low, SCK low for CS_GAP half-periods before the first edge
// LOAD  | TXREADY high; waits (indefinitely) for the next TX byte
// SHIFT | 16 half-periods: sample MISO on rise, drive next MOSI bit on fall
// HOLD  | SS low, SCK low for CS_GAP half-periods, then DONE and back to IDLE
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = SPI_CLK_DIV_50M,
  parameter int CS_GAP  = 2,
  parameter int LEN_W   = 6
) (
  input  logic             SPI_MASTER_CLOCK_50,
  input  logic             SPI_MASTER_RESET_InHigh,
  input  logic             SPI_MASTER_START_In,
  input  logic [LEN_W-1:0] SPI_MASTER_LEN_InBus,
  input  logic [7:0]       SPI_MASTER_TXDATA_InBus,
  input  logic             SPI_MASTER_TXVALID_In,
  output logic             SPI_MASTER_TXREADY_Out,
  output logic [7:0]       SPI_MASTER_RXDATA_OutBus,
  output logic             SPI_MASTER_RXVALID_Out,
  output logic             SPI_MASTER_BUSY_Out,
  output logic             SPI_MASTER_DONE_Out,
  output logic             SPI_MASTER_SCK_Out,
  output logic             SPI_MASTER_MOSI_Out,
  input  logic             SPI_MASTER_MISO_In,
  output logic             SPI_MASTER_SS_OutLow
);

  localparam int BB = SPI_BYTE_BITS;
  // CS_GAP is counted in the 4-bit half-period counter, so it must be 1..16.
  localparam logic [3:0] GAP_LAST   = 4'(CS_GAP - 1);
  localparam logic [3:0] SHIFT_LAST = 4'(2 * BB - 1);
  localparam logic       SCK_IDLE   = 1'(SPI_CPOL);

  spi_state_e       state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [BB-1:0]    tx_sr_q, tx_sr_d;
  logic [BB-1:0]    rx_sr_q, rx_sr_d;
  logic [BB-1:0]    rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             done_q, done_d;
  logic             mosi_q, mosi_d;
  logic             sck_q, sck_d;
  logic             ss_q, busy_q;

  logic       tick, rise, fall;
  logic [3:0] hp;

  spi_master_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk_i   (SPI_MASTER_CLOCK_50),
    .rst_i   (SPI_MASTER_RESET_InHigh),
    .en_i    (spi_timed_state(state_q)),
    .clr_i   (state_d != state_q),
    .shift_i (state_q == ST_SHIFT),
    .tick_o  (tick),
    .hp_o    (hp),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    done_d     = 1'b0;
    mosi_d     = mosi_q;
    sck_d      = (state_q == ST_SHIFT) ? sck_q : SCK_IDLE;

    unique case (state_q)
      ST_IDLE: begin
        if (SPI_MASTER_START_In && (SPI_MASTER_LEN_InBus != '0)) begin
          rem_d   = SPI_MASTER_LEN_InBus;
          state_d = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (tick && (hp == GAP_LAST)) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        if (SPI_MASTER_TXVALID_In) begin
          tx_sr_d = SPI_MASTER_TXDATA_InBus;
          mosi_d  = SPI_MASTER_TXDATA_InBus[BB-1];
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (rise) begin
          sck_d   = 1'b1;
          rx_sr_d = {rx_sr_q[BB-2:0], SPI_MASTER_MISO_In};
        end
        if (fall) begin
          sck_d = 1'b0;
          if (hp == SHIFT_LAST) begin
            // Byte complete: MOSI keeps the LSB, no further update.
            rx_data_d  = rx_sr_q;
            rx_valid_d = 1'b1;
            rem_d      = rem_q - LEN_W'(1);
            state_d    = (rem_q == LEN_W'(1)) ? ST_HOLD : ST_LOAD;
          end else begin
            tx_sr_d = {tx_sr_q[BB-2:0], 1'b0};
            mosi_d  = tx_sr_q[BB-2];
          end
        end
      end

      ST_HOLD: begin
        if (tick && (hp == GAP_LAST)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // SS and BUSY are registered from the next state so SS never glitches on
  // state-decode transitions.
  always_ff @(posedge SPI_MASTER_CLOCK_50) begin
    if (SPI_MASTER_RESET_InHigh) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      mosi_q     <= 1'b0;
      sck_q      <= SCK_IDLE;
      ss_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
      mosi_q     <= mosi_d;
      sck_q      <= sck_d;
      ss_q       <= (state_d == ST_IDLE);
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign SPI_MASTER_TXREADY_Out   = (state_q == ST_LOAD);
  assign SPI_MASTER_RXDATA_OutBus = rx_data_q;
  assign SPI_MASTER_RXVALID_Out   = rx_valid_q;
  assign SPI_MASTER_BUSY_Out      = busy_q;
  assign SPI_MASTER_DONE_Out      = done_q;
  assign SPI_MASTER_SCK_Out       = sck_q;
  assign SPI_MASTER_MOSI_Out      = mosi_q;
  assign SPI_MASTER_SS_OutLow     = ss_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master. The expected waveform of every output is laid out on
// an absolute cycle timeline computed from the transaction plan (start cycle,
// bytes, per-byte TX stalls, MISO wiring); one compare step checks all outputs
// against it every cycle. Literal checks pin latency, edge counts and data.
module tb_spi_master;

  localparam int D    = 2;
  localparam int G    = 2;
  localparam int LW   = 6;
  localparam int SH   = 16 * D;
  localparam int MAXC = 16384;

  logic          clk = 1'b0;
  logic          rst, start, txv, miso;
  logic [LW-1:0] len;
  logic [7:0]    txd;
  logic          txr, rxv, busy, done, sck, mosi, ss;
  logic [7:0]    rxd;
  int            mm;

  always #5 clk = ~clk;

  // 0: loopback, 1: tied high, 2: inverted loopback
  assign miso = (mm == 0) ? mosi : (mm == 1) ? 1'b1 : ~mosi;

  spi_master #(.CLK_DIV(D), .CS_GAP(G), .LEN_W(LW)) dut (
    .SPI_MASTER_CLOCK_50      (clk),
    .SPI_MASTER_RESET_InHigh  (rst),
    .SPI_MASTER_START_In      (start),
    .SPI_MASTER_LEN_InBus     (len),
    .SPI_MASTER_TXDATA_InBus  (txd),
    .SPI_MASTER_TXVALID_In    (txv),
    .SPI_MASTER_TXREADY_Out   (txr),
    .SPI_MASTER_RXDATA_OutBus (rxd),
    .SPI_MASTER_RXVALID_Out   (rxv),
    .SPI_MASTER_BUSY_Out      (busy),
    .SPI_MASTER_DONE_Out      (done),
    .SPI_MASTER_SCK_Out       (sck),
    .SPI_MASTER_MOSI_Out      (mosi),
    .SPI_MASTER_MISO_In       (miso),
    .SPI_MASTER_SS_OutLow     (ss)
  );

  // expected timeline
  bit         e_ss[MAXC], e_sck[MAXC], e_busy[MAXC], e_done[MAXC];
  bit         e_rxv[MAXC], e_txr[MAXC], e_mosi[MAXC];
  logic [7:0] e_rxd[MAXC];

  // current plan
  logic [7:0] p_tx[64];
  int         p_stall[64];
  int         p_hs[64];
  int         p_done;

  int tests = 0, fails = 0, cyc = 0;

  // monitors
  int  n_rise, n_ssl, n_done, hs_seen, rxv_cyc;
  int  rxq[$];
  logic prev_sck = 1'b0;

  task automatic set_cyc(input int t, input bit s, input bit k, input bit b,
                         input bit r, input bit m, input logic [7:0] d);
    if (t < MAXC) begin
      e_ss[t] = s; e_sck[t] = k; e_busy[t] = b; e_txr[t] = r;
      e_mosi[t] = m; e_rxd[t] = d; e_rxv[t] = 1'b0; e_done[t] = 1'b0;
    end
  endtask

  task automatic fill_idle(input int from, input bit m, input logic [7:0] d);
    for (int t = from; t < MAXC; t++) set_cyc(t, 1'b1, 1'b0, 1'b0, 1'b0, m, d);
  endtask

  // Timeline of a transaction whose START is driven in cycle c0.
  task automatic plan(input int c0, input int n, input int m);
    int a, h, p;
    bit mo;
    logic [7:0] rx;
    mo = e_mosi[c0];
    rx = e_rxd[c0];
    for (int t = c0 + 1; t <= c0 + G * D; t++) set_cyc(t, 0, 0, 1, 0, mo, rx);
    a = c0 + G * D + 1;
    for (int k = 0; k < n; k++) begin
      h = a + p_stall[k];
      p_hs[k] = h;
      for (int t = a; t <= h; t++) set_cyc(t, 0, 0, 1, 1, mo, rx);
      if (k > 0 && a < MAXC) e_rxv[a] = 1'b1;
      for (int r = 0; r < SH; r++) begin
        p = r / D;
        set_cyc(h + 1 + r, 0, (p % 2) == 1, 1, 0, p_tx[k][7 - p / 2], rx);
      end
      mo = p_tx[k][0];
      rx = (m == 0) ? p_tx[k] : (m == 1) ? 8'hFF : ~p_tx[k];
      a = h + SH + 1;
    end
    for (int t = a; t < a + G * D; t++) set_cyc(t, 0, 0, 1, 0, mo, rx);
    if (a < MAXC) e_rxv[a] = 1'b1;
    p_done = a + G * D;
    fill_idle(p_done, mo, rx);
    if (p_done < MAXC) e_done[p_done] = 1'b1;
  endtask

  task automatic check_cycle();
    logic [6:0] ev, av;
    if (cyc < MAXC) begin
      ev = {e_ss[cyc], e_sck[cyc], e_busy[cyc], e_done[cyc], e_rxv[cyc], e_txr[cyc], e_mosi[cyc]};
      av = {ss, sck, busy, done, rxv, txr, mosi};
      tests++;
      if (av !== ev || rxd !== e_rxd[cyc]) begin
        fails++;
        $display("FAIL cycle %0d {ss,sck,busy,done,rxv,txr,mosi}/rxdata: got %b/%h expected %b/%h",
                 cyc, av, rxd, ev, e_rxd[cyc]);
      end
    end
    if (sck === 1'b1 && prev_sck === 1'b0) n_rise++;
    prev_sck = sck;
    if (ss === 1'b0) n_ssl++;
    if (done === 1'b1) n_done++;
    if (rxv === 1'b1) begin rxq.push_back(int'(rxd)); rxv_cyc = cyc; end
    if (txr === 1'b1 && txv === 1'b1) hs_seen = cyc;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      txd = 8'($urandom);
      step();
    end
  endtask

  task automatic lit(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int rx_at(input int k);
    return (k < rxq.size()) ? rxq[k] : -1;
  endfunction

  task automatic clr_mon();
    n_rise = 0; n_ssl = 0; n_done = 0; hs_seen = -1; rxv_cyc = -1;
    rxq.delete();
  endtask

  // Drives a planned transaction; optionally pokes START while busy.
  task automatic run_txn(input int c0, input int n, input bit poke);
    wait_cyc(c0);
    start = 1'b1;
    len = LW'(n);
    step();
    start = 1'b0;
    len = LW'($urandom);
    if (poke) begin
      wait_cyc(c0 + 3);
      start = 1'b1;
      len = LW'(5);
      step();
      start = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      wait_cyc(p_hs[k]);
      txv = 1'b1;
      txd = p_tx[k];
      step();
      txv = 1'b0;
    end
    wait_cyc(p_done);
  endtask

  initial begin
    int c0, n, r;
    logic [7:0] exp_rx[64];
    rst = 1'b1; start = 1'b0; len = '0; txd = '0; txv = 1'b0; mm = 0;
    fill_idle(0, 1'b0, 8'h00);
    clr_mon();
    @(posedge clk);
    cyc = 1;
    #1;
    step(); step();
    rst = 1'b0;
    step(); step();

    // single byte A5 in loopback
    clr_mon();
    mm = 0; p_tx[0] = 8'hA5; p_stall[0] = 0;
    c0 = cyc + 2;
    plan(c0, 1, 0);
    run_txn(c0, 1, 1'b0);
    step(); step();
    lit("t1_accept_to_rxvalid", rxv_cyc - (hs_seen + 1), 32);
    lit("t1_sck_rises", n_rise, 8);
    lit("t1_ss_low_cycles", n_ssl, 41);
    lit("t1_done_pulses", n_done, 1);
    lit("t1_rx0", rx_at(0), 'hA5);

    // three bytes, TX withheld 10 clocks before byte 2
    clr_mon();
    p_tx[0] = 8'h01; p_tx[1] = 8'h80; p_tx[2] = 8'hFF;
    p_stall[0] = 0; p_stall[1] = 10; p_stall[2] = 0;
    c0 = cyc + 1;
    plan(c0, 3, 0);
    run_txn(c0, 3, 1'b0);
    step();
    lit("t2_rx0", rx_at(0), 'h01);
    lit("t2_rx1", rx_at(1), 'h80);
    lit("t2_rx2", rx_at(2), 'hFF);
    lit("t2_done_pulses", n_done, 1);
    lit("t2_sck_rises", n_rise, 24);

    // MISO tied high, TX 00
    clr_mon();
    mm = 1; p_tx[0] = 8'h00; p_stall[0] = 2;
    c0 = cyc + 3;
    plan(c0, 1, 1);
    run_txn(c0, 1, 1'b0);
    step();
    lit("t3_rx_tied_high", rx_at(0), 'hFF);
    mm = 0;

    // START with LEN=0 is ignored
    clr_mon();
    start = 1'b1; len = '0;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) step();
    lit("t4_len0_ss_low", n_ssl, 0);
    lit("t4_len0_done", n_done, 0);

    // START poked while busy in a LEN=2 transfer
    clr_mon();
    p_tx[0] = 8'h3C; p_tx[1] = 8'hC3; p_stall[0] = 1; p_stall[1] = 0;
    c0 = cyc + 1;
    plan(c0, 2, 0);
    run_txn(c0, 2, 1'b1);
    for (int i = 0; i < 20; i++) step();
    lit("t5_bytes", rxq.size(), 2);
    lit("t5_done", n_done, 1);

    // reset after the 4th SCK rise of the first byte
    clr_mon();
    p_tx[0] = 8'($urandom); p_tx[1] = 8'h55; p_stall[0] = 0; p_stall[1] = 0;
    c0 = cyc + 1;
    plan(c0, 2, 0);
    wait_cyc(c0);
    start = 1'b1; len = LW'(2);
    step();
    start = 1'b0;
    wait_cyc(p_hs[0]);
    txv = 1'b1; txd = p_tx[0];
    step();
    txv = 1'b0;
    r = p_hs[0] + 1 + 7 * D;
    wait_cyc(r);
    rst = 1'b1;
    fill_idle(r + 1, 1'b0, 8'h00);
    step();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) step();
    lit("t6_rises_before_reset", n_rise, 4);
    lit("t6_rxvalid_after_reset", rxq.size(), 0);
    lit("t6_done_after_reset", n_done, 0);
    clr_mon();
    p_tx[0] = 8'h9E; p_stall[0] = 0;
    c0 = cyc + 1;
    plan(c0, 1, 0);
    run_txn(c0, 1, 1'b0);
    step();
    lit("t6_fresh_rx", rx_at(0), 'h9E);

    // randomized transactions
    for (int it = 0; it < 20; it++) begin
      clr_mon();
      n  = $urandom_range(1, 6);
      mm = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin
        p_tx[k] = 8'($urandom);
        p_stall[k] = $urandom_range(0, 4);
        exp_rx[k] = (mm == 0) ? p_tx[k] : (mm == 1) ? 8'hFF : ~p_tx[k];
      end
      c0 = cyc + $urandom_range(1, 4);
      plan(c0, n, mm);
      run_txn(c0, n, 1'b0);
      step();
      lit("rand_byte_count", rxq.size(), n);
      for (int k = 0; k < n; k++) lit("rand_rx", rx_at(k), int'(exp_rx[k]));
    end

    for (int i = 0; i < 5; i++) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
